int_ctrl: RTL
=============

// Module: int_ctrl
// PURPOSE
//  Interrupt/exception controller directly upstream of the next-PC stage. Collects the
//  external button interrupt and the EX-stage illegal-instruction and ecall exceptions.
//  Arbitrates them and drives INT_Signal/INT_PEND into NPC, so NPC steers to the trap
//  vector and saves SEPC. Tracks the exception level (EXL) from trap entry until the
//  handler's return (NPC_INT_RET); nesting is not supported.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  stable-sample count for button debounce (used only with BUTTON_DEBOUNCE_EN)
// PORTS
//  clk          in   1  core clock; all state updates on posedge
//  rst          in   1  synchronous reset, active-high
//  pc_write     in   1  PC update enable (same signal that feeds NPC PCWrite); low = stall
//  npc_op       in   3  NPC operation of the instruction in EX (NPC_* codes)
//  exc_illegal  in   1  EX-stage illegal-instruction flag; held by pipeline while stalled
//  exc_ecall    in   1  EX-stage ecall flag; held by pipeline while stalled
//  btn_raw      in   1  asynchronous button input, active-high
//  int_en       in   1  global enable for the button interrupt; exceptions are not maskable
//  INT_Signal   out  1  trap taken this cycle (combinational, to NPC and pipeline flush)
//  INT_PEND     out  3  cause code of the taken trap; INT_NONE when INT_Signal=0
//  EXL_Set      out  1  exception level: 1 while a handler is running (registered)
//  exc_lost     out  1  sticky: a sync exception was dropped while EXL=1 (registered)
// BEHAVIOUR
//  Reset (rst=1 at posedge): EXL_Set=0, exc_lost=0, btn_pend=0, sync/edge/debounce regs=0.
//   While rst=1, INT_Signal=0 and INT_PEND=INT_NONE regardless of inputs.
//  Button path: 2-FF synchronizer -> prev-level reg -> rise = sync2 & ~prev.
//   A rise sets sticky btn_pend at the next posedge. Repeated rises while pending merge into one.
//   Latency: btn_raw first sampled high at edge k -> btn_pend=1 after edge k+2.
//  Take condition (comb): take = pc_write & ~EXL_Set & ~rst & (exc_illegal | exc_ecall | (btn_pend & int_en)).
//   INT_Signal = take.
//  Priority (comb): illegal > ecall > button.
//   INT_PEND = int_illegal_instr / int_ecall / int_buttom for the winner; INT_NONE otherwise.
//  FSM, 2 states:
//   IDLE (EXL_Set=0) --take@posedge--> TRAP (EXL_Set=1)
//   TRAP --pc_write & npc_op==NPC_INT_RET @posedge--> IDLE
//   NPC_INT_RET seen in IDLE: no state change.
//  Button clearing: btn_pend clears at the posedge where button is taken.
//   A rise arriving in that same cycle re-sets btn_pend (set wins over clear).
//  Losing arbitration: a lower-priority source is not lost. btn_pend stays set.
//   The pipeline re-presents the exception, or the flush squashes it.
//  Stall (pc_write=0): no take, FSM and btn_pend hold, button edges still recorded.
//  In TRAP:
//   - button rises stay pending and are taken in the first eligible cycle after return.
//   - exc_illegal/exc_ecall with pc_write=1 are dropped and set exc_lost (cleared only by rst).
//  Return with pending button: EXL clears at posedge N; button taken earliest cycle N+1, never in the return cycle.
//  int_en=0: button stays pending indefinitely; taken when int_en returns to 1.
//  Reset mid-handler: EXL forced 0, pending button discarded.
// CONFIGURATION
//  BUTTON_DEBOUNCE_EN defined:
//   - counter of width $clog2(DEBOUNCE_CYCLES+1) between sync2 and the edge detector.
//   - the debounced level changes only after sync2 differs from it for DEBOUNCE_CYCLES consecutive cycles.
//   - button latency increases by DEBOUNCE_CYCLES.
//  BUTTON_DEBOUNCE_EN undefined: no counter; edge detect on sync2 directly; DEBOUNCE_CYCLES unused.
// STRUCTURE
//  Shared package (ctrl_encode_def.v):
//   - existing int_buttom, int_illegal_instr, int_ecall, NPC_INT_RET.
//   - add INT_NONE (3'b000) and localparams ST_IDLE/ST_TRAP.
//  Sub-module btn_sync: synchronizer + optional debounce + rise detect; outputs a 1-cycle btn_rise.
//  int_ctrl holds arbitration, btn_pend, FSM and exc_lost.
// TESTING
//  1. rst=1 for 2 cycles, then exc_ecall=1, pc_write=1
//     -> same cycle INT_Signal=1, INT_PEND=int_ecall; EXL_Set=1 next cycle.
//  2. exc_illegal=1 and exc_ecall=1 together, with btn_pend=1 and int_en=1
//     -> INT_PEND=int_illegal_instr; btn_pend still 1 afterwards.
//  3. btn_raw rises at edge 10, int_en=1, no debounce
//     -> btn_pend=1 after edge 12; INT_Signal=1 in the following cycle.
//  4. EXL=1, button rise, then npc_op=NPC_INT_RET with pc_write=1 at edge N
//     -> EXL_Set=0 after N; INT_Signal=1, INT_PEND=int_buttom in cycle N+1.
//  5. EXL=1, exc_ecall=1 with pc_write=1
//     -> INT_Signal=0, exc_lost=1 and stays 1 until rst.
//  6. BUTTON_DEBOUNCE_EN, DEBOUNCE_CYCLES=4, btn_raw glitch of 3 cycles
//     -> no btn_pend. 6-cycle pulse -> btn_pend set exactly once.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared encodings for the interrupt controller: trap cause codes, NPC ops and FSM states.
package int_ctrl_pkg;

    localparam logic [2:0] INT_NONE          = 3'b000;
    localparam logic [2:0] int_buttom        = 3'b001;
    localparam logic [2:0] int_illegal_instr = 3'b010;
    localparam logic [2:0] int_ecall         = 3'b011;

    localparam logic [2:0] NPC_PLUS4   = 3'b000;
    localparam logic [2:0] NPC_INT_RET = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_TRAP = 1'b1
    } int_state_e;

    // Fixed priority: illegal beats ecall beats button.
    function automatic logic [2:0] int_cause(input logic illegal, input logic ecall);
        logic [2:0] cause;
        if (illegal) begin
            cause = int_illegal_instr;
        end else if (ecall) begin
            cause = int_ecall;
        end else begin
            cause = int_buttom;
        end
        return cause;
    endfunction

endpackage

// File: rtl/int_ctrl_btn_sync.sv
// Button synchronizer with rise detection; debounce counter present when BUTTON_DEBOUNCE_EN is defined.
module btn_sync #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_rise
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic level_s;

`ifdef BUTTON_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt_r;
    logic          db_level_r;

    // Debounced level flips only after sync2 disagrees for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= '0;
            db_level_r <= 1'b0;
        end else if (sync2_r != db_level_r) begin
            if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_r      <= '0;
                db_level_r <= sync2_r;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else begin
            cnt_r <= '0;
        end
    end

    assign level_s = db_level_r;
`else
    assign level_s = sync2_r;
`endif

    // Two-stage synchronizer plus previous-level register for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            prev_r  <= level_s;
        end
    end

    assign btn_rise = level_s & ~prev_r;

endmodule

// File: rtl/int_ctrl.sv
// Trap arbitration, button pending flag, EXL state machine and lost-exception flag.
// Optional button debounce is enabled with the BUTTON_DEBOUNCE_EN macro.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pc_write,
    input  logic [2:0] npc_op,
    input  logic       exc_illegal,
    input  logic       exc_ecall,
    input  logic       btn_raw,
    input  logic       int_en,
    output logic       INT_Signal,
    output logic [2:0] INT_PEND,
    output logic       EXL_Set,
    output logic       exc_lost
);

    int_state_e state_r;
    int_state_e state_nxt_s;
    logic       btn_pend_r;
    logic       exc_lost_r;
    logic       btn_rise_s;
    logic       take_s;
    logic       btn_take_s;
    logic [2:0] cause_s;

    btn_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_sync (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_rise (btn_rise_s)
    );

    // Arbitration and next-state logic.
    always_comb begin
        take_s      = pc_write & (state_r == ST_IDLE) & ~rst
                    & (exc_illegal | exc_ecall | (btn_pend_r & int_en));
        cause_s     = INT_NONE;
        btn_take_s  = 1'b0;
        state_nxt_s = state_r;
        if (take_s) begin
            cause_s    = int_cause(exc_illegal, exc_ecall);
            btn_take_s = ~exc_illegal & ~exc_ecall;
        end else begin
            cause_s    = INT_NONE;
        end
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    state_nxt_s = ST_TRAP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_TRAP: begin
                if (pc_write && (npc_op == NPC_INT_RET)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_TRAP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, pending button (a new rise wins over the clear) and sticky lost flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            btn_pend_r <= 1'b0;
            exc_lost_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (btn_rise_s) begin
                btn_pend_r <= 1'b1;
            end else if (btn_take_s) begin
                btn_pend_r <= 1'b0;
            end else begin
                btn_pend_r <= btn_pend_r;
            end
            if ((state_r == ST_TRAP) && pc_write && (exc_illegal || exc_ecall)) begin
                exc_lost_r <= 1'b1;
            end else begin
                exc_lost_r <= exc_lost_r;
            end
        end
    end

    assign INT_Signal = take_s;
    assign INT_PEND   = cause_s;
    assign EXL_Set    = (state_r == ST_TRAP);
    assign exc_lost   = exc_lost_r;

endmodule
